// File: rtl/asg_env_pkg.sv
// rtl/asg_env_pkg.sv - shared state encoding and widths for the ASG amplitude-envelope generator
package asg_env_pkg;

    localparam int ENV_AW = 14;
    localparam int ENV_FW = 16;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_HOLD    = 3'd2,
        ENV_DECAY   = 3'd3,
        ENV_SUSTAIN = 3'd4,
        ENV_RELEASE = 3'd5
    } env_state_t;

endpackage

// File: rtl/asg_env_ramp.sv
// rtl/asg_env_ramp.sv - one saturating fixed-point step of the level accumulator toward a target
module asg_env_ramp
    import asg_env_pkg::*;
#(
    parameter int AW = ENV_AW,
    parameter int FW = ENV_FW
) (
    input  logic signed [AW+FW-1:0] acc,
    input  logic        [AW+FW-1:0] step,
    input  logic signed [AW-1:0]    target,
    input  logic                    dir,
    output logic signed [AW+FW-1:0] acc_next,
    output logic                    reached
);

    // Two guard bits: a full-range unsigned step added to a full-range level never wraps.
    localparam int XW = AW + FW + 2;

    logic signed [XW-1:0] acc_x;
    logic signed [XW-1:0] step_x;
    logic signed [XW-1:0] tgt_x;
    logic signed [XW-1:0] sum_x;

    // dir=1 rises toward target, dir=0 falls; a zero step or a crossed target lands exactly on it.
    always_comb begin
        acc_x    = {{2{acc[AW+FW-1]}}, acc};
        step_x   = {2'b00, step};
        tgt_x    = {{2{target[AW-1]}}, target, {FW{1'b0}}};
        sum_x    = dir ? (acc_x + step_x) : (acc_x - step_x);
        reached  = (step == '0) || (dir ? (sum_x >= tgt_x) : (sum_x <= tgt_x));
        acc_next = reached ? tgt_x[AW+FW-1:0] : sum_x[AW+FW-1:0];
    end

endmodule

// File: rtl/asg_envelope_gen.sv
// rtl/asg_envelope_gen.sv - ADSR amplitude-envelope FSM driving amp_mod; ASG_ENV_LOOP_EN enables auto-restart
module asg_envelope_gen
    import asg_env_pkg::*;
#(
    parameter int AW = ENV_AW,
    parameter int FW = ENV_FW,
    parameter int HW = 32
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rstn_i,
    input  logic                 trig_i,
    input  logic                 stop_i,
    input  logic                 set_rst_i,
    input  logic signed [AW-1:0] set_base_i,
    input  logic signed [AW-1:0] set_peak_i,
    input  logic signed [AW-1:0] set_sus_i,
    input  logic [AW+FW-1:0]     set_att_i,
    input  logic [AW+FW-1:0]     set_dec_i,
    input  logic [AW+FW-1:0]     set_rel_i,
    input  logic [HW-1:0]        set_hold_i,
    input  logic                 set_loop_i,
    output logic signed [AW-1:0] amp_mod_o,
    output logic                 busy_o,
    output logic [2:0]           state_o,
    output logic                 done_o
);

    env_state_t               state;
    logic signed [AW+FW-1:0]  acc;
    logic [HW-1:0]            hold_cnt;

    logic [AW+FW-1:0]         ramp_step;
    logic signed [AW-1:0]     ramp_target;
    logic                     ramp_dir;
    logic signed [AW+FW-1:0]  ramp_next;
    logic                     ramp_reached;
    logic                     loop_restart;

`ifdef ASG_ENV_LOOP_EN
    assign loop_restart = set_loop_i;
`else
    logic unused_loop;
    assign loop_restart = 1'b0;
    assign unused_loop  = set_loop_i;
`endif

    // Select the step, target and direction of the single shared ramp for the current state.
    always_comb begin
        ramp_step   = set_rel_i;
        ramp_target = set_base_i;
        ramp_dir    = 1'b0;
        case (state)
            ENV_ATTACK: begin
                ramp_step   = set_att_i;
                ramp_target = set_peak_i;
                ramp_dir    = 1'b1;
            end
            ENV_DECAY: begin
                ramp_step   = set_dec_i;
                ramp_target = set_sus_i;
            end
            default: ;
        endcase
    end

    asg_env_ramp #(.AW(AW), .FW(FW)) u_ramp (
        .acc      (acc),
        .step     (ramp_step),
        .target   (ramp_target),
        .dir      (ramp_dir),
        .acc_next (ramp_next),
        .reached  (ramp_reached)
    );

    // Envelope sequencer: soft reset beats note-off, note-off beats the ramp, retrigger only from RELEASE.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state    <= ENV_IDLE;
            acc      <= '0;
            hold_cnt <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (set_rst_i) begin
                state    <= ENV_IDLE;
                acc      <= {set_base_i, {FW{1'b0}}};
                hold_cnt <= '0;
            end else begin
                case (state)
                    ENV_IDLE: begin
                        if (trig_i) state <= ENV_ATTACK;
                        else        acc   <= {set_base_i, {FW{1'b0}}};
                    end
                    ENV_ATTACK: begin
                        if (stop_i) begin
                            state <= ENV_RELEASE;
                        end else begin
                            acc <= ramp_next;
                            if (ramp_reached) begin
                                state    <= ENV_HOLD;
                                hold_cnt <= set_hold_i;
                            end
                        end
                    end
                    ENV_HOLD: begin
                        if (stop_i)                state    <= ENV_RELEASE;
                        else if (hold_cnt == '0)   state    <= ENV_DECAY;
                        else                       hold_cnt <= hold_cnt - 1'b1;
                    end
                    ENV_DECAY: begin
                        if (stop_i) begin
                            state <= ENV_RELEASE;
                        end else begin
                            acc <= ramp_next;
                            if (ramp_reached) state <= ENV_SUSTAIN;
                        end
                    end
                    ENV_SUSTAIN: begin
                        if (stop_i) state <= ENV_RELEASE;
                    end
                    ENV_RELEASE: begin
                        if (trig_i) begin
                            state <= ENV_ATTACK;
                        end else begin
                            acc <= ramp_next;
                            if (ramp_reached) begin
                                done_o <= 1'b1;
                                state  <= loop_restart ? ENV_ATTACK : ENV_IDLE;
                            end
                        end
                    end
                    default: state <= ENV_IDLE;
                endcase
            end
        end
    end

    assign amp_mod_o = acc[AW+FW-1:FW];
    assign busy_o    = (state != ENV_IDLE);
    assign state_o   = state;

endmodule

// File: tb/tb_asg_envelope_gen.sv
// tb/tb_asg_envelope_gen.sv - self-checking bench for asg_envelope_gen
module tb_asg_envelope_gen;

    localparam int AW = 14;
    localparam int FW = 16;
    localparam int HW = 32;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 trig = 1'b0, stop = 1'b0, srst = 1'b0, loop_req = 1'b0;
    logic signed [AW-1:0] base = '0, peak = '0, sus = '0;
    logic [AW+FW-1:0]     att = '0, dec = '0, rel = '0;
    logic [HW-1:0]        hold = '0;
    logic signed [AW-1:0] amp;
    logic                 busy, done;
    logic [2:0]           st;

    int checks = 0;
    int failures = 0;

    // reference model: level in 1/65536 units, phase number, hold cycles remaining
    int     m_st = 0;
    longint m_lvl = 0;
    longint m_hold = 0;
    bit     m_done = 0;

    always #5 clk = ~clk;

    asg_envelope_gen #(.AW(AW), .FW(FW), .HW(HW)) dut (
        .dac_clk_i(clk), .dac_rstn_i(rstn), .trig_i(trig), .stop_i(stop),
        .set_rst_i(srst), .set_base_i(base), .set_peak_i(peak), .set_sus_i(sus),
        .set_att_i(att), .set_dec_i(dec), .set_rel_i(rel), .set_hold_i(hold),
        .set_loop_i(loop_req), .amp_mod_o(amp), .busy_o(busy), .state_o(st), .done_o(done)
    );

    typedef struct {
        bit trig; bit stop; bit rst;
        int exp_state; int exp_amp; bit exp_done;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Move a level toward a target by a step; the direction is fixed by the phase, not the values.
    task automatic move(input bit up, input longint step, input longint tgt, output bit hit);
        longint n;
        n = up ? m_lvl + step : m_lvl - step;
        hit = (step == 0) || (up ? n >= tgt : n <= tgt);
        m_lvl = hit ? tgt : n;
    endtask

    task automatic model_step();
        longint b, p, s;
        bit hit;
        b = longint'(base) * 65536;
        p = longint'(peak) * 65536;
        s = longint'(sus) * 65536;
        m_done = 0;
        if (srst) begin
            m_st = 0; m_lvl = b; m_hold = 0;
        end else if (m_st == 0) begin
            if (trig) m_st = 1; else m_lvl = b;
        end else if (m_st == 5) begin
            if (trig) m_st = 1;
            else begin
                move(0, longint'(rel), b, hit);
                if (hit) begin
                    m_done = 1;
`ifdef ASG_ENV_LOOP_EN
                    m_st = loop_req ? 1 : 0;
`else
                    m_st = 0;
`endif
                end
            end
        end else if (stop) begin
            m_st = 5;
        end else if (m_st == 1) begin
            move(1, longint'(att), p, hit);
            if (hit) begin m_st = 2; m_hold = longint'(hold); end
        end else if (m_st == 2) begin
            if (m_hold == 0) m_st = 3; else m_hold--;
        end else if (m_st == 3) begin
            move(0, longint'(dec), s, hit);
            if (hit) m_st = 4;
        end
    endtask

    // One clock: advance the model, let the edge pass, compare, clear the strobes.
    task automatic step(input bit t, input bit s, input bit r);
        trig = t; stop = s; srst = r;
        model_step();
        @(posedge clk);
        #1;
        chk("model_amp", longint'(amp), m_lvl >>> 16);
        chk("model_state", longint'(st), longint'(m_st));
        chk("model_done", longint'(done), longint'(m_done));
        chk("model_busy", longint'(busy), longint'(m_st != 0));
        trig = 0; stop = 0; srst = 0;
    endtask

    task automatic count_state(input int s, output int n);
        n = 0;
        while (st == 3'(s) && n < 400) begin
            n++;
            step(0, 0, 0);
        end
        if (n >= 400) chk("state_timeout", longint'(st), -1);
    endtask

    task automatic set_full();
        base = 0; peak = 4096; sus = 2048; hold = 10;
        att = 30'h0100_0000; dec = 30'h0080_0000; rel = 30'h0080_0000;
    endtask

    vec_t vecs[$];
    int n;
    int guard;

    initial begin
        // zero-step table: att=dec=rel=0, hold=0, plus trig/stop priority rows
        vecs.push_back('{1,0,0, 1,   0,0});
        vecs.push_back('{0,0,0, 2,4096,0});
        vecs.push_back('{0,0,0, 3,4096,0});
        vecs.push_back('{0,0,0, 4,2048,0});
        vecs.push_back('{0,0,0, 4,2048,0});
        vecs.push_back('{0,1,0, 5,2048,0});
        vecs.push_back('{0,0,0, 0,   0,1});
        vecs.push_back('{0,0,0, 0,   0,0});
        vecs.push_back('{1,1,0, 1,   0,0});
        vecs.push_back('{0,0,0, 2,4096,0});
        vecs.push_back('{1,0,0, 3,4096,0});
        vecs.push_back('{1,1,0, 5,4096,0});
        vecs.push_back('{1,1,0, 1,4096,0});
        vecs.push_back('{0,0,0, 2,4096,0});
        vecs.push_back('{0,0,1, 0,   0,0});
        vecs.push_back('{0,1,0, 0,   0,0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_amp", longint'(amp), 0);
        chk("reset_state", longint'(st), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        rstn = 1;

        base = 0; peak = 4096; sus = 2048; hold = 0; att = 0; dec = 0; rel = 0;
        step(0, 0, 0);
        foreach (vecs[i]) begin
            step(vecs[i].trig, vecs[i].stop, vecs[i].rst);
            chk($sformatf("vec%0d_state", i), longint'(st), longint'(vecs[i].exp_state));
            chk($sformatf("vec%0d_amp", i), longint'(amp), longint'(vecs[i].exp_amp));
            chk($sformatf("vec%0d_done", i), longint'(done), longint'(vecs[i].exp_done));
        end

        // full envelope
        set_full();
        step(1, 0, 0);
        count_state(1, n); chk("full_attack_cycles", n, 16);
        chk("full_peak", longint'(amp), 4096);
        count_state(2, n); chk("full_hold_cycles", n, 11);
        count_state(3, n); chk("full_decay_cycles", n, 16);
        chk("full_sustain_state", longint'(st), 4);
        chk("full_sustain_amp", longint'(amp), 2048);
        repeat (50) step(0, 0, 0);
        step(0, 1, 0);
        count_state(5, n); chk("full_release_cycles", n, 16);
        chk("full_done", longint'(done), 1);
        chk("full_end_amp", longint'(amp), 0);
        step(0, 0, 0);
        chk("full_done_once", longint'(done), 0);

        // early stop during attack
        step(1, 0, 0);
        repeat (5) step(0, 0, 0);
        chk("early_level", longint'(amp), 1280);
        step(0, 1, 0);
        chk("early_release_state", longint'(st), 5);
        chk("early_release_amp", longint'(amp), 1280);
        count_state(5, n); chk("early_release_cycles", n, 10);
        chk("early_done", longint'(done), 1);

        // retrigger mid-release at 1024
        step(1, 0, 0);
        count_state(1, n); count_state(2, n); count_state(3, n);
        step(0, 1, 0);
        guard = 0;
        while (amp != 14'sd1024 && guard < 40) begin guard++; step(0, 0, 0); end
        chk("retrig_reach_1024", longint'(amp), 1024);
        step(1, 0, 0);
        chk("retrig_state", longint'(st), 1);
        chk("retrig_amp", longint'(amp), 1024);
        step(0, 0, 0);
        chk("retrig_rise", longint'(amp), 1280);

        // trig+stop together in DECAY
        count_state(1, n); count_state(2, n);
        chk("prio_in_decay", longint'(st), 3);
        step(1, 1, 0);
        chk("prio_release", longint'(st), 5);
        count_state(5, n);

        // soft reset during HOLD
        base = 14'sd37;
        step(1, 0, 0);
        count_state(1, n);
        step(0, 0, 1);
        chk("srst_state", longint'(st), 0);
        chk("srst_amp", longint'(amp), 37);
        chk("srst_done", longint'(done), 0);
        step(0, 0, 0);
        base = 0;
        step(0, 0, 0);

        // asynchronous reset between edges during ATTACK
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        #2 rstn = 0;
        #1;
        chk("arst_amp", longint'(amp), 0);
        chk("arst_state", longint'(st), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_done", longint'(done), 0);
        @(posedge clk);
        #1 rstn = 1;
        m_st = 0; m_lvl = 0; m_hold = 0; m_done = 0;

        // randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) begin
                base = 14'($urandom); peak = 14'($urandom); sus = 14'($urandom);
                att = ($urandom_range(0, 7) == 0) ? '0 : 30'($urandom_range(1 << 18, 1 << 24));
                dec = ($urandom_range(0, 7) == 0) ? '0 : 30'($urandom_range(1 << 18, 1 << 24));
                rel = ($urandom_range(0, 7) == 0) ? '0 : 30'($urandom_range(1 << 18, 1 << 24));
                hold = 32'($urandom_range(0, 20));
                loop_req = 1'($urandom);
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
